// File: rtl/bayer_shift_sequencer.sv
// Four-position pixel-shift capture sequencer: steps the actuator, captures one
// RGGB frame per position and streams per-channel samples with high-res coordinates.
module bayer_shift_sequencer #(
  parameter int DATA_W        = 12,
  parameter int WIDTH         = 773,
  parameter int HEIGHT        = 495,
  parameter int SETTLE_CYCLES = 64,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              shift_req,
  input  logic              shift_done,
  output logic [1:0]        shift_pos,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] raw_red_data,
  output logic [DATA_W-1:0] raw_green_data,
  output logic [DATA_W-1:0] raw_blue_data,
  output logic [2:0]        chan,
  output logic [10:0]       out_x,
  output logic [9:0]        out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  // state      | meaning
  // S_IDLE     | waiting for start
  // S_MOVE     | shift_req high until the actuator reports shift_done
  // S_SETTLE   | settle down-counter running
  // S_WAIT_SOF | waiting for sof so capture aligns with a frame start
  // S_CAPTURE  | buffering pixels, tracking sensor col/row
  // S_DRAIN    | waiting for FIFO and output register to empty
  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_WAIT_SOF, S_CAPTURE, S_DRAIN
  } state_t;

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = DATA_W + 3 + 11 + 10;
  localparam logic [2:0] CH_R = 3'b001;
  localparam logic [2:0] CH_G = 3'b010;
  localparam logic [2:0] CH_B = 3'b100;

  state_t             state, state_nxt;
  logic [1:0]         pos_nxt;
  logic               settle_load;
  logic [CNT_W-1:0]   settle_cnt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               pix_accept, last_pix, drained;

  logic [ENT_W-1:0]   mem [0:(2**AW)-1];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count, occ;
  logic               full, xfer, load_out, fifo_wr;

  logic               dx, dy;
  logic [2:0]         chan_w;
  logic [10:0]        x_w;
  logic [9:0]         y_w;
  logic [ENT_W-1:0]   wr_entry, rd_entry;
  logic [DATA_W-1:0]  rd_data;
  logic [2:0]         rd_chan;
  logic [10:0]        rd_x;
  logic [9:0]         rd_y;

  assign pix_accept = pix_valid &&
                      ((state == S_CAPTURE) || ((state == S_WAIT_SOF) && sof));
  assign last_pix   = (col == COL_W'(WIDTH - 1)) && (row == ROW_W'(HEIGHT - 1));
  assign drained    = (count == '0) && !out_valid;

  assign shift_req  = (state == S_MOVE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DRAIN) && drained && (shift_pos == 2'd3);

  always_comb begin
    state_nxt   = state;
    pos_nxt     = shift_pos;
    settle_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_MOVE;
          pos_nxt   = 2'd0;
        end
      end
      S_MOVE: begin
        if (shift_done) begin
          state_nxt   = S_SETTLE;
          settle_load = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_nxt = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (pix_accept) state_nxt = last_pix ? S_DRAIN : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (pix_accept && last_pix) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          if (shift_pos == 2'd3) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_MOVE;
            pos_nxt   = shift_pos + 2'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shift_pos <= 2'd0;
    end else begin
      state     <= state_nxt;
      shift_pos <= pos_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (settle_load) begin
      settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Geometry advances on every accepted pixel, including ones dropped on a full buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (state == S_SETTLE) begin
      col <= '0;
      row <= '0;
    end else if (pix_accept) begin
      if (col == COL_W'(WIDTH - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign dx = shift_pos[0] ^ shift_pos[1];
  assign dy = shift_pos[1];

  always_comb begin
    chan_w = CH_G;
    if (!row[0] && !col[0])     chan_w = CH_R;
    else if (row[0] && col[0])  chan_w = CH_B;
  end

  assign x_w      = 11'({col, dx});
  assign y_w      = 10'({row, dy});
  assign wr_entry = {pix_data, chan_w, x_w, y_w};

  // Capacity counts the output register so FIFO_DEPTH samples can be held in total.
  assign xfer     = out_valid && out_ready;
  assign load_out = (count != '0) && (!out_valid || out_ready);
  assign occ      = count + {{AW{1'b0}}, out_valid};
  assign full     = (occ == (AW + 1)'(FIFO_DEPTH));
  assign fifo_wr  = pix_accept && (!full || xfer);

  always_ff @(posedge clock) begin
    if (fifo_wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (load_out) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, load_out})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      overrun <= 1'b0;
    end else if (pix_accept && !fifo_wr) begin
      overrun <= 1'b1;
    end
  end

  assign rd_entry = mem[rd_ptr];
  assign {rd_data, rd_chan, rd_x, rd_y} = rd_entry;

  // Only the addressed colour port updates; the other two keep their last sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      chan           <= 3'b000;
      out_x          <= '0;
      out_y          <= '0;
      raw_red_data   <= '0;
      raw_green_data <= '0;
      raw_blue_data  <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      chan      <= rd_chan;
      out_x     <= rd_x;
      out_y     <= rd_y;
      if (rd_chan == CH_R)      raw_red_data   <= rd_data;
      else if (rd_chan == CH_B) raw_blue_data  <= rd_data;
      else                      raw_green_data <= rd_data;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_shift_sequencer.sv
// Directed bench for bayer_shift_sequencer: a 4x2 instance for sequencing and
// handshake behaviour, an 8x4 instance for buffer overflow.
module tb_bayer_shift_sequencer;
  localparam int DW = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, start, start_b, shift_done, sof, pix_valid, out_ready;
  logic [DW-1:0] pix_data;

  logic          shift_req, busy, frame_done, overrun, out_valid;
  logic [1:0]    shift_pos;
  logic [DW-1:0] red, green, blue;
  logic [2:0]    chan;
  logic [10:0]   out_x;
  logic [9:0]    out_y;

  logic          shift_req_b, busy_b, frame_done_b, overrun_b, out_valid_b;
  logic [1:0]    shift_pos_b;
  logic [DW-1:0] red_b, green_b, blue_b;
  logic [2:0]    chan_b;
  logic [10:0]   out_x_b;
  logic [9:0]    out_y_b;

  bayer_shift_sequencer #(.DATA_W(DW), .WIDTH(4), .HEIGHT(2), .SETTLE_CYCLES(3), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .shift_req(shift_req),
    .shift_done(shift_done), .shift_pos(shift_pos), .sof(sof), .pix_valid(pix_valid),
    .pix_data(pix_data), .raw_red_data(red), .raw_green_data(green), .raw_blue_data(blue),
    .chan(chan), .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  bayer_shift_sequencer #(.DATA_W(DW), .WIDTH(8), .HEIGHT(4), .SETTLE_CYCLES(3), .FIFO_DEPTH(16)) dut_big (
    .clock(clock), .reset_n(reset_n), .start(start_b), .shift_req(shift_req_b),
    .shift_done(shift_done), .shift_pos(shift_pos_b), .sof(sof), .pix_valid(pix_valid),
    .pix_data(pix_data), .raw_red_data(red_b), .raw_green_data(green_b), .raw_blue_data(blue_b),
    .chan(chan_b), .out_x(out_x_b), .out_y(out_y_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sel(input logic [2:0] c, input logic [DW-1:0] r,
                             input logic [DW-1:0] g, input logic [DW-1:0] b);
    if (c == 3'b001) return int'(r);
    if (c == 3'b100) return int'(b);
    return int'(g);
  endfunction

  int s_data[$], s_chan[$], s_x[$], s_y[$];
  int b_data[$], b_chan[$], b_x[$], b_y[$];
  int fd_cnt = 0;
  int fd_idle = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        s_data.push_back(sel(chan, red, green, blue));
        s_chan.push_back(int'(chan));
        s_x.push_back(int'(out_x));
        s_y.push_back(int'(out_y));
      end
      if (out_valid_b && out_ready) begin
        b_data.push_back(sel(chan_b, red_b, green_b, blue_b));
        b_chan.push_back(int'(chan_b));
        b_x.push_back(int'(out_x_b));
        b_y.push_back(int'(out_y_b));
      end
      if (frame_done) begin
        fd_cnt++;
        if (!busy) fd_idle++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_req(input bit big, input string tag);
    int k = 0;
    while (((big ? shift_req_b : shift_req) !== 1'b1) && k < 400) begin
      tick(1);
      k++;
    end
    check({tag, " shift_req"}, big ? shift_req_b : shift_req, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy !== 1'b0) && k < 400) begin
      tick(1);
      k++;
    end
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic settle(input bit big);
    shift_done = 1'b1;
    tick(1);
    shift_done = 1'b0;
    check("req drop", big ? shift_req_b : shift_req, 0);
    tick(5);
  endtask

  task automatic stream(input int base, input int n, input int done_at, input int start_at);
    for (int i = 0; i < n; i++) begin
      pix_valid  = 1'b1;
      pix_data   = DW'(base + i);
      sof        = (i == 0);
      shift_done = (i == done_at);
      start      = (i == start_at);
      tick(1);
    end
    pix_valid  = 1'b0;
    sof        = 1'b0;
    shift_done = 1'b0;
    start      = 1'b0;
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; start = 1'b0; start_b = 1'b0; shift_done = 1'b0;
    sof = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("rst busy", busy, 0);
    check("rst shift_req", shift_req, 0);
    check("rst shift_pos", shift_pos, 0);
    check("rst out_valid", out_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst frame_done", frame_done, 0);
    check("rst chan", chan, 0);
    check("rst out_x", out_x, 0);
    check("rst red", red, 0);

    // Full four-position sequence, ready always high
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start busy", busy, 1);
    for (int p = 0; p < 4; p++) begin
      wait_req(1'b0, "seqA");
      check("seqA pos", shift_pos, p);
      settle(1'b0);
      stream(1, 8, -1, -1);
    end
    wait_idle("seqA end");
    check("frame_done count", fd_cnt, 1);
    check("frame_done busy", fd_idle, 0);
    check("sample count", s_data.size(), 32);
    check("p0 px1 data", s_data[0], 1);
    check("p0 px1 chan", s_chan[0], 1);
    check("p0 px1 x", s_x[0], 0);
    check("p0 px1 y", s_y[0], 0);
    check("p0 px6 data", s_data[5], 6);
    check("p0 px6 chan", s_chan[5], 4);
    check("p0 px6 x", s_x[5], 2);
    check("p0 px6 y", s_y[5], 2);
    check("p1 px1 x", s_x[8], 1);
    check("p1 px1 y", s_y[8], 0);
    check("p2 px8 data", s_data[23], 8);
    check("p2 px8 chan", s_chan[23], 4);
    check("p2 px8 x", s_x[23], 7);
    check("p2 px8 y", s_y[23], 3);
    check("p3 px8 x", s_x[31], 6);
    check("p3 px8 y", s_y[31], 3);
    check("p3 px3 chan", s_chan[26], 1);
    check("seqA overrun", overrun, 0);

    // Backpressure over a whole frame, late shift_done, start while busy, reset mid-capture
    s_data.delete(); s_chan.delete(); s_x.delete(); s_y.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    out_ready = 1'b0;
    wait_req(1'b0, "seqB p0");
    settle(1'b0);
    stream(1, 8, -1, -1);
    tick(3);
    check("hold overrun", overrun, 0);
    check("hold valid", out_valid, 1);
    check("hold no xfer", s_data.size(), 0);
    check("hold red", red, 1);
    check("hold chan", chan, 1);
    tick(5);
    check("hold2 x", out_x, 0);
    check("hold2 y", out_y, 0);
    check("hold2 red", red, 1);
    check("hold2 valid", out_valid, 1);
    check("drain waits", shift_req, 0);
    out_ready = 1'b1;
    wait_req(1'b0, "seqB p1");
    check("seqB p0 count", s_data.size(), 8);
    check("seqB p1 pos", shift_pos, 1);

    stream(100, 26, 20, -1);
    check("late done req", shift_req, 0);
    tick(2);
    stream(1, 8, -1, 3);
    check("start ignored pos", shift_pos, 1);
    wait_req(1'b0, "seqB p2");
    check("seqB p2 pos", shift_pos, 2);
    check("late done overrun", overrun, 0);
    check("seqB p1 count", s_data.size(), 16);
    check("late p1 first data", s_data[8], 1);
    check("late p1 first x", s_x[8], 1);
    bad = 0;
    foreach (s_data[i]) if (s_data[i] >= 100) bad++;
    check("dropped pixels", bad, 0);

    out_ready = 1'b0;
    settle(1'b0);
    stream(1, 5, -1, -1);
    check("pre-reset valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("reset valid", out_valid, 0);
    check("reset req", shift_req, 0);
    check("reset busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick(2);
    stream(1, 8, -1, -1);
    tick(4);
    check("post-reset busy", busy, 0);
    check("post-reset valid", out_valid, 0);
    check("post-reset count", s_data.size(), 16);
    check("post-reset pos", shift_pos, 0);

    // 8x4 frame into a 16-sample buffer with no readout
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    out_ready = 1'b0;
    wait_req(1'b1, "big p0");
    settle(1'b1);
    stream(1, 32, -1, -1);
    tick(3);
    check("big overrun", overrun_b, 1);
    check("big busy", busy_b, 1);
    check("big drain waits", shift_req_b, 0);
    check("big valid", out_valid_b, 1);
    out_ready = 1'b1;
    wait_req(1'b1, "big p1");
    check("big pos", shift_pos_b, 1);
    check("big count", b_data.size(), 16);
    check("big first data", b_data[0], 1);
    check("big last data", b_data[15], 16);
    check("big last x", b_x[15], 14);
    check("big last y", b_y[15], 2);
    check("big last chan", b_chan[15], 4);
    check("small idle", busy, 0);
    reset_n = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
